alarm_cmd_parser: RTL and testbench
===================================

Name: alarm_cmd_parser

Overview:
- Byte-stream parser between the UART receiver and the alarm-trigger comparator.
- Consumes ASCII bytes, recognises the alarm-set command `A` `hh` `:` `mm` `:` `ss` followed by CR or LF, and range-checks the fields.
- On a valid command, emits a one-cycle `alarm_set` strobe with binary hour/min/sec that the comparator latches.
- Malformed, out-of-range or stalled commands are discarded and flagged with an error pulse.

Parameters:
- TIMEOUT_CYCLES, 50_000_000 — idle cycles allowed between bytes of one command before it is aborted; 0 disables the timeout.

Ports:
- clk  in  1  — system clock.
- rst_n  in  1  — asynchronous, active-low reset.
- rx_data  in  8  — received UART byte.
- rx_valid  in  1  — one-cycle strobe; rx_data is valid this cycle.
- alarm_set  out  1  — one-cycle strobe; a valid command has completed.
- alarm_hour_out  out  5  — binary hour, 0-23.
- alarm_min_out  out  6  — binary minute, 0-59.
- alarm_sec_out  out  6  — binary second, 0-59.
- cmd_error  out  1  — one-cycle strobe; a command was aborted.
- busy  out  1  — high while in any state other than IDLE.

Behaviour:
- Reset: async on rst_n=0.
  - alarm_set=0, cmd_error=0, busy=0.
  - alarm_hour_out, alarm_min_out, alarm_sec_out = 0.
  - FSM goes to IDLE; digit registers and timeout counter are cleared.
  - Reset mid-command discards the partial command with no strobe.
- FSM states: IDLE, H1, H0, C1, M1, M0, C2, S1, S0, TERM. Advances only on cycles with rx_valid=1.
  - IDLE: `A` (0x41) or `a` (0x61) -> H1. Any other byte is ignored silently (no error).
  - H1/H0, M1/M0, S1/S0: byte must be `0`-`9`. Store (byte-0x30) as a 4-bit digit, then go to the next state. A non-digit is an error.
  - C1, C2: byte must be `:` (0x3A), else error.
  - TERM: byte 0x0D or 0x0A -> range check, else error.
- Resync: `A`/`a` received in any non-IDLE state abandons the partial command, pulses cmd_error, and goes to H1 (not IDLE).
- Range check, computed in TERM on the terminator byte:
  - hour = h1*10+h0; valid if ≤23.
  - min = m1*10+m0; valid if ≤59.
  - sec = s1*10+s0; valid if ≤59.
  - Products are formed as tens*8 + tens*2; results are truncated to 5/6/6 bits only after the check.
- Success: on the cycle after the terminator is accepted, the outputs are updated and alarm_set=1 for exactly one cycle. The FSM returns to IDLE on that same edge.
- Latency: terminator rx_valid at cycle N -> alarm_set at cycle N+1.
- Fields hold their value until the next successful command. An error never alters them.
- Error: cmd_error=1 for one cycle at N+1. Then IDLE (or H1 on resync).
- Timeout: a counter runs in non-IDLE states and clears on every rx_valid. On reaching TIMEOUT_CYCLES it pulses cmd_error and goes to IDLE. rx_valid in the same cycle as expiry has priority and the byte is processed.
- alarm_set and cmd_error are never high in the same cycle.
- Back-to-back rx_valid on consecutive cycles must be accepted without loss.

Optional Feature:
- Macro: ALARM_CMD_ACK_EN.
- When defined, adds ports:
  - tx_data out 8.
  - tx_valid out 1.
  - tx_ready in 1.
- Acknowledgement bytes:
  - A success queues `K` (0x4B).
  - An error (including timeout) queues `E` (0x45).
  - A single-entry holding register keeps tx_valid high until tx_ready=1.
- A new ack while the register is still full overwrites it; the newest result wins.
- Without the macro, these ports and the logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package `alarm_pkg`:
  - FSM state encoding.
  - ASCII constants: CHAR_A, CHAR_a, CHAR_COLON, CHAR_CR, CHAR_LF, CHAR_0, CHAR_K, CHAR_E.
  - Limits: MAX_HOUR=23, MAX_MIN=59, MAX_SEC=59.
- One sub-module: `bcd2_to_bin`, a combinational tens/units -> binary converter with a `limit` compare, instantiated three times.

Test Plan:
- Valid command: send "A07:30:15\r" -> one alarm_set pulse one cycle after `\r`; hour=7, min=30, sec=15; cmd_error stays 0.
- Hour out of range: send "A24:00:00\n" -> cmd_error pulse; alarm_set stays 0; outputs keep the previous values (7/30/15).
- Resync: send "A12:3A23:59:59\r" -> cmd_error pulse at the second `A`; then alarm_set with 23/59/59.
- Timeout: with TIMEOUT_CYCLES=100, send "A1" then idle for 100 cycles -> cmd_error pulse; busy falls to 0; a following "A00:00:00\n" succeeds with 0/0/0.
- Async reset: assert rst_n=0 mid-command after "A09:1" -> all outputs 0 immediately; busy=0; a following "A09:15:00\r" produces 9/15/0.
- ACK path (ALARM_CMD_ACK_EN defined, tx_ready held 0): send a valid then an invalid command -> tx_data=0x45 holds; raise tx_ready -> one transfer, then tx_valid drops.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm command parser: FSM encoding, ASCII codes and field limits.
package alarm_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_H1,
      ST_H0,
      ST_C1,
      ST_M1,
      ST_M0,
      ST_C2,
      ST_S1,
      ST_S0,
      ST_TERM
   } state_t;

   localparam logic [7:0] CHAR_A     = 8'h41;
   localparam logic [7:0] CHAR_a     = 8'h61;
   localparam logic [7:0] CHAR_COLON = 8'h3A;
   localparam logic [7:0] CHAR_CR    = 8'h0D;
   localparam logic [7:0] CHAR_LF    = 8'h0A;
   localparam logic [7:0] CHAR_0     = 8'h30;
   localparam logic [7:0] CHAR_9     = 8'h39;
   localparam logic [7:0] CHAR_K     = 8'h4B;
   localparam logic [7:0] CHAR_E     = 8'h45;

   localparam logic [6:0] MAX_HOUR = 7'd23;
   localparam logic [6:0] MAX_MIN  = 7'd59;
   localparam logic [6:0] MAX_SEC  = 7'd59;

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= CHAR_0) && (b <= CHAR_9);
   endfunction

endpackage

// File: rtl/bcd2_to_bin.sv
// Two-digit decimal (tens/units) to binary converter with an inclusive upper-limit check.
module bcd2_to_bin (
   input  logic [3:0] tens,
   input  logic [3:0] units,
   input  logic [6:0] limit,
   output logic [6:0] bin,
   output logic       in_range
);

   logic [6:0] tens_x8;
   logic [6:0] tens_x2;

   // tens*10 built from shifts so no multiplier is inferred
   assign tens_x8  = {tens, 3'b000};
   assign tens_x2  = {2'b00, tens, 1'b0};
   assign bin      = tens_x8 + tens_x2 + {3'b000, units};
   assign in_range = (bin <= limit);

endmodule

// File: rtl/alarm_cmd_parser.sv
// Parses "A hh:mm:ss <CR|LF>" from a UART byte stream and strobes a range-checked alarm time.
// Optional ACK byte output ('K'/'E') is enabled with `define ALARM_CMD_ACK_EN.
//
// state   | meaning
// --------+--------------------------------------------
// IDLE    | waiting for 'A'/'a', other bytes ignored
// H1, H0  | expecting hour tens / units digit
// C1      | expecting ':' after hour
// M1, M0  | expecting minute tens / units digit
// C2      | expecting ':' after minute
// S1, S0  | expecting second tens / units digit
// TERM    | expecting CR or LF, then range check
module alarm_cmd_parser
   import alarm_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       alarm_set,
   output logic [4:0] alarm_hour_out,
   output logic [5:0] alarm_min_out,
   output logic [5:0] alarm_sec_out,
   output logic       cmd_error,
   output logic       busy
`ifdef ALARM_CMD_ACK_EN
   ,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready
`endif
);

   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LOAD =
      (TIMEOUT_CYCLES > 0) ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;

   state_t     state_q, state_d;
   logic [3:0] h1_q, h0_q, m1_q, m0_q, s1_q, s0_q;
   logic [TMO_W-1:0] tmo_q;

   logic       set_d, err_d;
   logic       byte_ok;
   state_t     adv_state;
   logic       is_cmd, is_dig, is_colon, is_term;
   logic [7:0] digit_full;
   logic [3:0] digit;
   logic       tmo_expire;

   logic [6:0] hour_bin, min_bin, sec_bin;
   logic       hour_ok, min_ok, sec_ok, range_ok;

   bcd2_to_bin u_hour (.tens(h1_q), .units(h0_q), .limit(MAX_HOUR), .bin(hour_bin), .in_range(hour_ok));
   bcd2_to_bin u_min  (.tens(m1_q), .units(m0_q), .limit(MAX_MIN),  .bin(min_bin),  .in_range(min_ok));
   bcd2_to_bin u_sec  (.tens(s1_q), .units(s0_q), .limit(MAX_SEC),  .bin(sec_bin),  .in_range(sec_ok));

   assign range_ok   = hour_ok && min_ok && sec_ok;
   assign is_cmd     = (rx_data == CHAR_A) || (rx_data == CHAR_a);
   assign is_dig     = is_digit(rx_data);
   assign is_colon   = (rx_data == CHAR_COLON);
   assign is_term    = (rx_data == CHAR_CR) || (rx_data == CHAR_LF);
   assign digit_full = rx_data - CHAR_0;
   assign digit      = digit_full[3:0];
   assign busy       = (state_q != ST_IDLE);

   // A byte arriving on the expiry cycle wins, so expiry is masked by rx_valid
   assign tmo_expire = (TIMEOUT_CYCLES > 0) && busy && !rx_valid && (tmo_q == '0);

   always_comb begin
      state_d   = state_q;
      set_d     = 1'b0;
      err_d     = 1'b0;
      byte_ok   = 1'b0;
      adv_state = ST_IDLE;
      if (rx_valid) begin
         if (state_q == ST_IDLE) begin
            if (is_cmd) state_d = ST_H1;
         end else if (is_cmd) begin
            err_d   = 1'b1;
            state_d = ST_H1;
         end else begin
            case (state_q)
               ST_H1:   begin byte_ok = is_dig;   adv_state = ST_H0;   end
               ST_H0:   begin byte_ok = is_dig;   adv_state = ST_C1;   end
               ST_C1:   begin byte_ok = is_colon; adv_state = ST_M1;   end
               ST_M1:   begin byte_ok = is_dig;   adv_state = ST_M0;   end
               ST_M0:   begin byte_ok = is_dig;   adv_state = ST_C2;   end
               ST_C2:   begin byte_ok = is_colon; adv_state = ST_S1;   end
               ST_S1:   begin byte_ok = is_dig;   adv_state = ST_S0;   end
               ST_S0:   begin byte_ok = is_dig;   adv_state = ST_TERM; end
               ST_TERM: begin byte_ok = is_term && range_ok; adv_state = ST_IDLE; end
               default: begin byte_ok = 1'b0;     adv_state = ST_IDLE; end
            endcase
            state_d = byte_ok ? adv_state : ST_IDLE;
            set_d   = byte_ok && (state_q == ST_TERM);
            err_d   = !byte_ok;
         end
      end else if (tmo_expire) begin
         err_d   = 1'b1;
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         alarm_set      <= 1'b0;
         cmd_error      <= 1'b0;
         alarm_hour_out <= '0;
         alarm_min_out  <= '0;
         alarm_sec_out  <= '0;
      end else begin
         state_q   <= state_d;
         alarm_set <= set_d;
         cmd_error <= err_d;
         if (set_d) begin
            alarm_hour_out <= 5'(hour_bin);
            alarm_min_out  <= 6'(min_bin);
            alarm_sec_out  <= 6'(sec_bin);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h1_q <= '0;
         h0_q <= '0;
         m1_q <= '0;
         m0_q <= '0;
         s1_q <= '0;
         s0_q <= '0;
      end else if (rx_valid && is_dig) begin
         case (state_q)
            ST_H1:   h1_q <= digit;
            ST_H0:   h0_q <= digit;
            ST_M1:   m1_q <= digit;
            ST_M0:   m0_q <= digit;
            ST_S1:   s1_q <= digit;
            ST_S0:   s0_q <= digit;
            default: ;
         endcase
      end
   end

   // Down-counter reloaded on every byte and while idle; expiry is the zero count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_q <= '0;
      end else if (rx_valid || (state_q == ST_IDLE)) begin
         tmo_q <= TMO_LOAD;
      end else if (tmo_q != '0) begin
         tmo_q <= tmo_q - 1'b1;
      end
   end

`ifdef ALARM_CMD_ACK_EN
   // Single holding register; a newer result overwrites an unsent one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_valid <= 1'b0;
         tx_data  <= '0;
      end else if (set_d) begin
         tx_valid <= 1'b1;
         tx_data  <= CHAR_K;
      end else if (err_d) begin
         tx_valid <= 1'b1;
         tx_data  <= CHAR_E;
      end else if (tx_ready) begin
         tx_valid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_alarm_cmd_parser.sv
// Self-checking bench for alarm_cmd_parser: directed cases plus randomized byte streams vs a queue-based model.
module tb_alarm_cmd_parser;

   localparam int TO = 100;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       alarm_set;
   logic [4:0] alarm_hour_out;
   logic [5:0] alarm_min_out;
   logic [5:0] alarm_sec_out;
   logic       cmd_error;
   logic       busy;
`ifdef ALARM_CMD_ACK_EN
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready = 1'b0;
   bit         tx_ready_cfg = 1'b0;
   bit         rand_ready = 1'b0;
   bit         exp_txv;
   int         exp_txd;
`endif

   always #5 clk = ~clk;

   alarm_cmd_parser #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .alarm_set(alarm_set),
      .alarm_hour_out(alarm_hour_out),
      .alarm_min_out(alarm_min_out),
      .alarm_sec_out(alarm_sec_out),
      .cmd_error(cmd_error),
      .busy(busy)
`ifdef ALARM_CMD_ACK_EN
      ,
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready)
`endif
   );

   int checks = 0;
   int failures = 0;

   // reference model: activity flag, bytes received since the last 'A', idle-cycle count
   bit           m_active;
   byte unsigned m_buf[$];
   int           m_idle;
   string        tmpl = "DD:DD:DDT";
   bit           exp_set, exp_err;
   int           exp_hour, exp_min, exp_sec;
   bit           chk_en = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_active = 1'b0;
      m_buf.delete();
      m_idle   = 0;
      exp_set  = 1'b0;
      exp_err  = 1'b0;
      exp_hour = 0;
      exp_min  = 0;
      exp_sec  = 0;
`ifdef ALARM_CMD_ACK_EN
      exp_txv  = 1'b0;
      exp_txd  = 0;
`endif
   endfunction

   function automatic void model_cmd(input bit v, input byte unsigned b);
      int  pos;
      byte cls;
      bit  ok;
      int  h, mi, s;
      exp_set = 1'b0;
      exp_err = 1'b0;
      if (!v) begin
         if (m_active) begin
            m_idle++;
            if (m_idle == TO) begin
               exp_err  = 1'b1;
               m_active = 1'b0;
               m_idle   = 0;
            end
         end
         return;
      end
      m_idle = 0;
      if (b == 8'h41 || b == 8'h61) begin
         if (m_active) exp_err = 1'b1;
         m_active = 1'b1;
         m_buf.delete();
         return;
      end
      if (!m_active) return;
      pos = m_buf.size();
      cls = tmpl[pos];
      if (cls == "D")      ok = (b >= 8'h30) && (b <= 8'h39);
      else if (cls == ":") ok = (b == 8'h3A);
      else                 ok = (b == 8'h0D) || (b == 8'h0A);
      if (!ok) begin
         exp_err  = 1'b1;
         m_active = 1'b0;
         return;
      end
      if (pos < 8) begin
         m_buf.push_back(b);
         return;
      end
      m_active = 1'b0;
      h  = (int'(m_buf[0]) - 48) * 10 + (int'(m_buf[1]) - 48);
      mi = (int'(m_buf[3]) - 48) * 10 + (int'(m_buf[4]) - 48);
      s  = (int'(m_buf[6]) - 48) * 10 + (int'(m_buf[7]) - 48);
      if (h <= 23 && mi <= 59 && s <= 59) begin
         exp_set  = 1'b1;
         exp_hour = h;
         exp_min  = mi;
         exp_sec  = s;
      end else begin
         exp_err = 1'b1;
      end
   endfunction

   function automatic void model_step(input bit v, input byte unsigned b, input bit rdy);
      model_cmd(v, b);
`ifdef ALARM_CMD_ACK_EN
      if (exp_set) begin
         exp_txv = 1'b1; exp_txd = 8'h4B;
      end else if (exp_err) begin
         exp_txv = 1'b1; exp_txd = 8'h45;
      end else if (exp_txv && rdy) begin
         exp_txv = 1'b0;
      end
`else
      if (rdy) m_idle = m_idle;
`endif
   endfunction

   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         chk("alarm_set", int'(alarm_set), int'(exp_set));
         chk("cmd_error", int'(cmd_error), int'(exp_err));
         chk("busy", int'(busy), int'(m_active));
         chk("hour", int'(alarm_hour_out), exp_hour);
         chk("min", int'(alarm_min_out), exp_min);
         chk("sec", int'(alarm_sec_out), exp_sec);
`ifdef ALARM_CMD_ACK_EN
         chk("tx_valid", int'(tx_valid), int'(exp_txv));
         if (exp_txv) chk("tx_data", int'(tx_data), exp_txd);
`endif
      end
   end

   task automatic cycle(input bit v, input byte unsigned b);
      bit rdy;
      @(negedge clk);
      rx_valid = v;
      rx_data  = b;
      rdy = 1'b0;
`ifdef ALARM_CMD_ACK_EN
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : tx_ready_cfg;
      rdy = tx_ready;
`endif
      if (rst_n) model_step(v, b, rdy);
      else       model_reset();
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) cycle(1'b1, s[i]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
   endtask

   initial begin
      byte unsigned q[$];
      int gap, r;
      rst_n = 1'b0;
      model_reset();
      chk_en = 1'b1;
      idle(3);
      chk("rst_busy", int'(busy), 0);
      chk("rst_hour", int'(alarm_hour_out), 0);
      chk("rst_set", int'(alarm_set), 0);
      rst_n = 1'b1;
      idle(2);

      // valid command, latency one cycle after the terminator
      send_str("A07:30:15");
      cycle(1'b1, 8'h0D);
      idle(1);
      chk("t1_set", int'(alarm_set), 1);
      chk("t1_err", int'(cmd_error), 0);
      chk("t1_hour", int'(alarm_hour_out), 7);
      chk("t1_min", int'(alarm_min_out), 30);
      chk("t1_sec", int'(alarm_sec_out), 15);
      chk("t1_model_hour", exp_hour, 7);
      idle(2);

      // hour out of range keeps previous fields
      send_str("A24:00:00");
      cycle(1'b1, 8'h0A);
      idle(1);
      chk("t2_err", int'(cmd_error), 1);
      chk("t2_set", int'(alarm_set), 0);
      chk("t2_hour", int'(alarm_hour_out), 7);
      chk("t2_min", int'(alarm_min_out), 30);
      chk("t2_sec", int'(alarm_sec_out), 15);
      idle(2);

      // resync on a second 'A'
      send_str("A12:3A");
      idle(1);
      chk("t3_resync_err", int'(cmd_error), 1);
      chk("t3_resync_busy", int'(busy), 1);
      send_str("23:59:59");
      cycle(1'b1, 8'h0D);
      idle(1);
      chk("t3_set", int'(alarm_set), 1);
      chk("t3_hour", int'(alarm_hour_out), 23);
      chk("t3_min", int'(alarm_min_out), 59);
      chk("t3_sec", int'(alarm_sec_out), 59);
      idle(2);

      // async reset mid-command clears outputs immediately
      send_str("A09:1");
      #1;
      rst_n = 1'b0;
      rx_valid = 1'b0;
      model_reset();
      #1;
      chk("t4_rst_hour", int'(alarm_hour_out), 0);
      chk("t4_rst_min", int'(alarm_min_out), 0);
      chk("t4_rst_sec", int'(alarm_sec_out), 0);
      chk("t4_rst_busy", int'(busy), 0);
      idle(2);
      rst_n = 1'b1;
      idle(1);
      send_str("A09:15:00");
      cycle(1'b1, 8'h0D);
      idle(1);
      chk("t4_set", int'(alarm_set), 1);
      chk("t4_hour", int'(alarm_hour_out), 9);
      chk("t4_min", int'(alarm_min_out), 15);
      chk("t4_sec", int'(alarm_sec_out), 0);
      idle(2);

      // timeout boundary: still busy after 99 idle cycles' effect, error after the 100th
      send_str("A1");
      idle(TO);
      chk("t5_pre_err", int'(cmd_error), 0);
      chk("t5_pre_busy", int'(busy), 1);
      idle(1);
      chk("t5_tmo_err", int'(cmd_error), 1);
      chk("t5_tmo_busy", int'(busy), 0);
      send_str("A00:00:00");
      cycle(1'b1, 8'h0A);
      idle(1);
      chk("t5_set", int'(alarm_set), 1);
      chk("t5_hour", int'(alarm_hour_out), 0);
      idle(2);

`ifdef ALARM_CMD_ACK_EN
      tx_ready_cfg = 1'b0;
      send_str("A01:02:03");
      cycle(1'b1, 8'h0D);
      send_str("A99:00:00");
      cycle(1'b1, 8'h0D);
      idle(4);
      chk("ack_valid_hold", int'(tx_valid), 1);
      chk("ack_data", int'(tx_data), 8'h45);
      tx_ready_cfg = 1'b1;
      idle(1);
      tx_ready_cfg = 1'b0;
      idle(1);
      chk("ack_drop", int'(tx_valid), 0);
      rand_ready = 1'b1;
`endif

      // randomized commands with corruption, truncation and varied gaps
      for (int n = 0; n < 250; n++) begin
         q.delete();
         if ($urandom_range(0, 9) == 0) q.push_back(8'($urandom_range(0, 255)));
         q.push_back($urandom_range(0, 1) ? 8'h41 : 8'h61);
         q.push_back(8'(48 + $urandom_range(0, 2)));
         q.push_back(8'(48 + $urandom_range(0, 9)));
         q.push_back(8'h3A);
         q.push_back(8'(48 + $urandom_range(0, 6)));
         q.push_back(8'(48 + $urandom_range(0, 9)));
         q.push_back(8'h3A);
         q.push_back(8'(48 + $urandom_range(0, 6)));
         q.push_back(8'(48 + $urandom_range(0, 9)));
         q.push_back($urandom_range(0, 1) ? 8'h0D : 8'h0A);
         r = $urandom_range(0, 9);
         if (r == 0) q[$urandom_range(0, q.size() - 1)] = 8'($urandom_range(0, 255));
         else if (r == 1) begin
            gap = $urandom_range(1, 8);
            while (q.size() > gap) void'(q.pop_back());
         end
         foreach (q[i]) begin
            cycle(1'b1, q[i]);
            r = $urandom_range(0, 49);
            if (r == 0)      gap = $urandom_range(TO - 2, TO + 1);
            else if (r < 35) gap = 0;
            else             gap = $urandom_range(1, 3);
            idle(gap);
         end
         idle($urandom_range(0, 2));
      end

      idle(TO + 5);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
